lc3b_mem_responder: RTL
=======================

Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b datapath memory port. It services the mem_read/mem_write requests that the control word raises, and returns a single-cycle mem_resp.
- Backed by an internal word-organised RAM. Supports byte enables and a programmable fixed wait-state latency.
- Sits in place of (or in front of) the cache/physical memory so that multi-cycle control FSMs can be exercised and verified against a deterministic responder.

Parameters:
- ADDR_WIDTH, 8, number of word-index bits; the RAM holds 2^ADDR_WIDTH 16-bit words.
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  read request; held by the requester until mem_resp is seen
- mem_write  input  1  write request; held by the requester until mem_resp is seen
- mem_address  input  16  byte address; word index = mem_address[ADDR_WIDTH:1]; bit 0 and bits above ADDR_WIDTH are ignored, so addresses alias/wrap
- mem_wdata  input  16  write data
- mem_byte_enable  input  2  bit0 selects bits 7:0, bit1 selects bits 15:8
- mem_resp  output  1  one-cycle completion pulse
- mem_rdata  output  16  read data; valid while mem_resp=1
- protocol_err  output  1  sticky error flag; cleared only by rst
- rd_count  output  16  completed reads (MEM_RESP_STATS_EN only)
- wr_count  output  16  completed writes (MEM_RESP_STATS_EN only)

Behaviour:
- Reset is synchronous. rst=1 at an edge gives: state IDLE, mem_resp=0, mem_rdata=0, protocol_err=0, wait counter 0, stats counters 0. RAM contents are not touched by reset; they are zero at time zero in simulation.
- Reset mid-access abandons the access: no write is committed and no mem_resp is issued.
- State IDLE:
  - If mem_read or mem_write is high at an edge, the request is accepted. Latch address word index, wdata, byte_enable and access type. Load wait counter = LATENCY-1. Go to WAIT.
- State WAIT:
  - Decrement the counter each cycle. When the counter is 0 at an edge, go to RESP.
  - Input changes during WAIT are ignored; latched values are used.
- State RESP (exactly one cycle, mem_resp=1):
  - Read: mem_rdata = RAM[latched index], sampled at the edge entering RESP. It therefore reflects every write already committed.
  - Write: RAM[index] is updated at the edge leaving RESP, per byte lane, only where the byte_enable bit is 1. mem_rdata keeps its previous value.
  - Then return to IDLE.
- Latency: with the request first high in cycle N, mem_resp=1 in cycle N+LATENCY. LATENCY=1 gives mem_resp in cycle N+1.
- Back-to-back accesses: the requester drops its request in the cycle after mem_resp. A request still high in IDLE is treated as a new access, so a held request produces repeated responses every LATENCY+1 cycles.
- mem_rdata holds its last read value between responses.
- Both mem_read and mem_write high at acceptance:
  - Set protocol_err=1.
  - Perform no RAM access.
  - Still complete the handshake: mem_resp after LATENCY cycles, with mem_rdata=16'h0000.
- byte_enable=2'b00 on a write: handshake completes, RAM is unchanged, and the access counts as a write.
- byte_enable is ignored on reads; the full word is returned.

Optional Feature:
- Macro: MEM_RESP_STATS_EN.
- Defined:
  - rd_count increments on each RESP cycle of a read.
  - wr_count increments on each RESP cycle of a write.
  - Both counters saturate at 16'hFFFF.
  - Protocol-error accesses count in neither.
  - Both clear on rst.
- Undefined: rd_count and wr_count are driven constant 0, and no counter flops are synthesised.

Test Plan:
- Reset, then idle for 10 cycles -> mem_resp=0, mem_rdata=0, protocol_err=0 throughout.
- LATENCY=3: write addr 16'h0010, wdata 16'hBEEF, be 2'b11, request raised in cycle 5 -> mem_resp only in cycle 8. Then read 16'h0010 -> mem_rdata=16'hBEEF with mem_resp 3 cycles after the request.
- Byte lanes: write 16'h1234 with be=2'b11, then write 16'hABCD to the same address with be=2'b01 -> read returns 16'h12CD. A further write with be=2'b10 of 16'h5600 -> read returns 16'h56CD.
- Aliasing (ADDR_WIDTH=8): write 16'h00AA to address 16'h0002 -> read of 16'h0202 and of 16'h0003 both return 16'h00AA.
- mem_read=mem_write=1 -> protocol_err goes 1 and stays 1, mem_resp after LATENCY with rdata 0, RAM unchanged. Only rst clears protocol_err.
- Assert rst in the WAIT cycle of a write to address 16'h0020 -> no mem_resp, and a later read of 16'h0020 returns its old value. With MEM_RESP_STATS_EN, after 2 reads and 1 write: rd_count=2, wr_count=1.

Source files
------------

// File: rtl/lc3b_mem_responder.sv
// rtl/lc3b_mem_responder.sv - deterministic wait-state memory responder for the LC-3b memory port
//
// Purpose: services mem_read/mem_write requests from the LC-3b datapath out of an
//   internal 2^ADDR_WIDTH x 16-bit RAM. Each accepted request completes with a
//   one-cycle mem_resp_o exactly LATENCY cycles after the request is first high.
//   Writes honour the two byte enables. A request with both read and write high
//   sets a sticky protocol error and completes without touching the RAM.
//
// Parameters:
//   ADDR_WIDTH - word-index bits; word index = mem_address_i[ADDR_WIDTH:1]
//   LATENCY    - request-to-response cycles, 1..15
//
// Ports:
//   clk_i              rising-edge clock
//   rst_i              synchronous active-high reset (RAM contents are kept)
//   mem_read_i         read request, held until mem_resp_o
//   mem_write_i        write request, held until mem_resp_o
//   mem_address_i      byte address; bit 0 and bits above ADDR_WIDTH ignored
//   mem_wdata_i        write data
//   mem_byte_enable_i  bit0 -> bits 7:0, bit1 -> bits 15:8 (writes only)
//   mem_resp_o         one-cycle completion pulse
//   mem_rdata_o        read data, valid with mem_resp_o, held between reads
//   protocol_err_o     sticky flag: read and write requested together
//   rd_count_o         completed reads  (MEM_RESP_STATS_EN, else 0)
//   wr_count_o         completed writes (MEM_RESP_STATS_EN, else 0)
//
// Optional feature macro: MEM_RESP_STATS_EN enables saturating access counters.

module lc3b_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [15:0] mem_address_i,
  input  logic [15:0] mem_wdata_i,
  input  logic [1:0]  mem_byte_enable_i,
  output logic        mem_resp_o,
  output logic [15:0] mem_rdata_o,
  output logic        protocol_err_o,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [1:0]            be_q, be_d;
  logic                  is_write_q, is_write_d;
  logic                  bad_q, bad_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  perr_q, perr_d;

  logic [15:0] mem_q [0:(2**ADDR_WIDTH)-1];

  // Address bits that only alias; collected so they are visibly intentional.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address_i[15:ADDR_WIDTH+1], mem_address_i[0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      is_write_q <= 1'b0;
      bad_q      <= 1'b0;
      rdata_q    <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      is_write_q <= is_write_d;
      bad_q      <= bad_d;
      rdata_q    <= rdata_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    is_write_d = is_write_q;
    bad_d      = bad_q;
    rdata_d    = rdata_q;
    perr_d     = perr_q;

    unique case (state_q)
      S_IDLE: begin
        if (mem_read_i || mem_write_i) begin
          idx_d      = mem_address_i[ADDR_WIDTH:1];
          wdata_d    = mem_wdata_i;
          be_d       = mem_byte_enable_i;
          is_write_d = mem_write_i;
          bad_d      = mem_read_i && mem_write_i;
          if (bad_d) begin
            perr_d = 1'b1;
          end
          cnt_d   = CNT_LOAD;
          // LATENCY=1 has no wait cycles at all: respond in the next cycle.
          state_d = (CNT_LOAD == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // The acceptance edge already used one cycle of latency, so the
        // counter expires on the edge where it would decrement to zero.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read data is captured on the edge entering RESP. The _d copies of the
    // latched fields are the incoming request when coming straight from IDLE.
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      if (bad_d) begin
        rdata_d = '0;
      end else if (!is_write_d) begin
        rdata_d = mem_q[idx_d];
      end
    end
  end

  // Writes commit on the edge leaving RESP; a reset on that edge abandons them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == S_RESP) && is_write_q && !bad_q) begin
      if (be_q[0]) begin
        mem_q[idx_q][7:0] <= wdata_q[7:0];
      end
      if (be_q[1]) begin
        mem_q[idx_q][15:8] <= wdata_q[15:8];
      end
    end
  end

  assign mem_resp_o     = (state_q == S_RESP);
  assign mem_rdata_o    = rdata_q;
  assign protocol_err_o = perr_q;

`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if ((state_q == S_RESP) && !bad_q) begin
      if (is_write_q) begin
        if (wr_cnt_q != 16'hFFFF) begin
          wr_cnt_q <= wr_cnt_q + 16'd1;
        end
      end else begin
        if (rd_cnt_q != 16'hFFFF) begin
          rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end
    end
  end

  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`else
  assign rd_count_o = 16'h0000;
  assign wr_count_o = 16'h0000;
`endif

endmodule
